array_mult_seq: RTL
===================

ARRAY_MULT_SEQ -- requirements
Module: array_mult_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits; it SHALL be at least 4 and a multiple of DIGIT.
REQ-002 The block SHALL have parameter DIGIT, default 4, giving the number of multiplier bits of b consumed per cycle; it SHALL be 1, 2, 4 or 8.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port in_valid, input, 1 bit: operands a and b are valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept operands.
REQ-007 Port a, input, WIDTH bits: multiplicand.
REQ-008 Port b, input, WIDTH bits: multiplier.
REQ-009 Port out_valid, output, 1 bit: the product on p is valid.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts p.
REQ-011 Port p, output, 2*WIDTH bits: product.
REQ-012 Port sgn, input, 1 bit, present only when SIGNED_EN is defined: when 1, a and b are two's complement; when 0, both are unsigned.

Function
REQ-013 The block SHALL use an FSM with three states: IDLE, RUN and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 When in_valid and in_ready are both 1 at a rising edge, the block SHALL capture a, b (and sgn), clear the accumulator and the digit counter, and move from IDLE to RUN.
REQ-016 In RUN, each cycle SHALL add a times the next DIGIT-bit slice of b, LSB slice first, into the accumulator at weight 2^(DIGIT*k), where k is the digit index.
REQ-017 After N = WIDTH/DIGIT RUN cycles, the FSM SHALL move to DONE; out_valid SHALL first be 1 exactly N rising edges after the accepting edge.
REQ-018 In DONE, p SHALL hold stable until out_valid and out_ready are both 1 at a rising edge; the FSM SHALL then return to IDLE.
REQ-019 out_ready held at 0 SHALL stall the block in DONE indefinitely with p unchanged.
REQ-020 While in_ready is 0, in_valid, a and b SHALL be ignored.
REQ-021 The product SHALL be exact modulo 2^(2*WIDTH) with no overflow; the accumulator SHALL be 2*WIDTH+1 bits internally and p SHALL be its low 2*WIDTH bits.
REQ-022 p SHALL be 0 whenever the block is not in DONE.

Reset
REQ-023 While rst_n is low, the block SHALL be in IDLE with in_ready=1, out_valid=0, p=0, and the accumulator and counter at 0.
REQ-024 Asserting rst_n in RUN or DONE SHALL abort the operation immediately; the block SHALL produce no result for that operation and SHALL accept new operands on the first edge after release.

Configuration
REQ-025 The block SHALL support exactly one macro, ARRAY_MULT_SIGNED_EN.
REQ-026 With ARRAY_MULT_SIGNED_EN defined, port sgn SHALL exist; when sgn=1, a SHALL be sign-extended in every partial product and the final (MS) digit of b SHALL carry negative weight, giving a two's complement product.
REQ-027 Without ARRAY_MULT_SIGNED_EN, port sgn SHALL be absent and the multiply SHALL be unsigned only.

Structure
REQ-028 Package array_mult_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH and DIGIT constants.
REQ-029 A combinational sub-module array_mult_digit SHALL form the (WIDTH+DIGIT+1)-bit partial product a x digit, including signed handling; the top level SHALL hold the FSM, the counter, the accumulator and the handshake.

Verification (WIDTH=16, DIGIT=4, N=4)
REQ-030 Drive a=0x0003, b=0x0005 accepted at edge E0 -> out_valid rises after edge E4 with p=0x0000000F; in_ready=0 from E0 until return to IDLE.
REQ-031 Drive a=0xFFFF, b=0xFFFF unsigned -> p=0xFFFE0001.
REQ-032 With ARRAY_MULT_SIGNED_EN and sgn=1: a=0xFFFF, b=0x0002 -> p=0xFFFFFFFE; a=0x8000, b=0x7FFF -> p=0xC0008000. With sgn=0: a=0x8000, b=0x7FFF -> p=0x3FFF8000.
REQ-033 Hold out_ready=0 for 10 cycles in DONE -> p and out_valid stay constant and in_valid pulses are ignored; raise out_ready -> one transfer occurs, then in_ready=1 on the next cycle.
REQ-034 Pulse rst_n low at the second RUN cycle -> out_valid=0, p=0 and in_ready=1 immediately; the next operands a=0x0010, b=0x0010 -> p=0x00000100 with nominal latency.
REQ-035 Run 1000 back-to-back random operations with random out_ready stalls against a reference product -> all products match and no operand is lost or duplicated.

Source files
------------

// File: rtl/array_mult_pkg.sv
// -----------------------------------------------------------------------------
// array_mult_pkg
// Shared definitions for the sequential digit-serial multiplier:
//   - state_e        : FSM states IDLE / RUN / DONE
//   - DEFAULT_WIDTH  : default operand width in bits
//   - DEFAULT_DIGIT  : default number of multiplier bits consumed per cycle
// -----------------------------------------------------------------------------
package array_mult_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_DIGIT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : array_mult_pkg

// File: rtl/array_mult_digit.sv
// -----------------------------------------------------------------------------
// array_mult_digit
// Combinational partial product a x digit, (WIDTH+DIGIT+1) bits, two's
// complement.
//   a_i     : multiplicand (WIDTH bits)
//   digit_i : one DIGIT-bit slice of the multiplier
//   sgn_i   : 1 = a is two's complement (sign-extended)
//   msd_i   : 1 = this is the most significant digit of b; combined with
//             sgn_i the digit is taken as signed (negative weight on its MSB)
//   pp_o    : partial product, exact in WIDTH+DIGIT+1 bits
// -----------------------------------------------------------------------------
module array_mult_digit
   import array_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DIGIT = DEFAULT_DIGIT
) (
   input  logic [WIDTH-1:0]     a_i,
   input  logic [DIGIT-1:0]     digit_i,
   input  logic                 sgn_i,
   input  logic                 msd_i,
   output logic [WIDTH+DIGIT:0] pp_o
);

   localparam int PW = WIDTH + DIGIT + 1;

   logic          a_sign;
   logic          d_sign;
   logic [PW-1:0] a_x;
   logic [PW-1:0] d_x;

   assign a_sign = sgn_i & a_i[WIDTH-1];
   assign d_sign = sgn_i & msd_i & digit_i[DIGIT-1];

   // Both operands are sign-extended to the result width, so the low PW bits
   // of a plain unsigned multiply are the exact two's complement product; the
   // magnitude always fits in PW bits.
   assign a_x  = {{(DIGIT + 1){a_sign}}, a_i};
   assign d_x  = {{(WIDTH + 1){d_sign}}, digit_i};
   assign pp_o = a_x * d_x;

endmodule : array_mult_digit

// File: rtl/array_mult_seq.sv
// -----------------------------------------------------------------------------
// array_mult_seq
// Sequential digit-serial multiplier: consumes DIGIT bits of b per cycle,
// producing a 2*WIDTH-bit product after WIDTH/DIGIT cycles, with valid/ready
// handshakes on both sides.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b               : multiplicand, multiplier (WIDTH bits)
//   sgn                : two's complement select (only with macro
//                        ARRAY_MULT_SIGNED_EN defined)
//   out_valid/out_ready: result handshake (out_valid high only in DONE)
//   p                  : product (2*WIDTH bits), 0 outside DONE
// Optional feature: define ARRAY_MULT_SIGNED_EN to add the sgn port and
// signed multiplication; otherwise the multiply is unsigned only.
// -----------------------------------------------------------------------------
module array_mult_seq
   import array_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DIGIT = DEFAULT_DIGIT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
`ifdef ARRAY_MULT_SIGNED_EN
   input  logic                 sgn,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p
);

   localparam int N  = WIDTH / DIGIT;
   localparam int PW = WIDTH + DIGIT + 1;
   localparam int AW = 2 * WIDTH + 1;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_e             state_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;        // shifts right one digit per RUN cycle
   logic               sgn_q;
   logic [CW-1:0]      cnt_q;
   logic [AW-1:0]      acc_q;
   logic [AW-1:0]      acc_d;
   logic [2*WIDTH-1:0] p_q;
   logic               in_ready_q;
   logic               out_valid_q;

   logic               sgn_in;
   logic               last_digit;
   logic [PW-1:0]      pp;
   logic [AW-1:0]      pp_ext;

`ifdef ARRAY_MULT_SIGNED_EN
   assign sgn_in = sgn;
`else
   assign sgn_in = 1'b0;
`endif

   assign last_digit = (cnt_q == LAST);

   array_mult_digit #(
      .WIDTH (WIDTH),
      .DIGIT (DIGIT)
   ) u_digit (
      .a_i     (a_q),
      .digit_i (b_q[DIGIT-1:0]),
      .sgn_i   (sgn_q),
      .msd_i   (last_digit),
      .pp_o    (pp)
   );

   // Partial product is signed; extend it to accumulator width before
   // weighting it by 2^(DIGIT*k).
   assign pp_ext = AW'($signed(pp));
   assign acc_d  = acc_q + (pp_ext << (cnt_q * DIGIT));

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values and the update order is irrelevant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sgn_q       <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         p_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  sgn_q      <= sgn_in;
                  cnt_q      <= '0;
                  acc_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               b_q   <= b_q >> DIGIT;
               cnt_q <= cnt_q + 1'b1;
               if (last_digit) begin
                  p_q         <= acc_d[2*WIDTH-1:0];
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  p_q         <= '0;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               p_q         <= '0;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign p         = p_q;

endmodule : array_mult_seq
